// File: rtl/sort_pkg.sv
// Shared defaults, state encoding and pad value for the sorted array loader.
package sort_pkg;

    localparam int SORT_N = 32;
    localparam int SORT_W = 32;

    localparam logic [SORT_W-1:0] PAD = {SORT_W{1'b1}};

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-exchange of two words: lo receives the minimum, hi the maximum.
module cmp_swap #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap_s;

    assign swap_s = (a > b);
    assign lo     = swap_s ? b : a;
    assign hi     = swap_s ? a : b;

endmodule

// File: rtl/sorted_array_loader.sv
// Collects up to N words, sorts them with an odd-even transposition network
// (one pass per cycle) and presents the padded array as a single held frame.
module sorted_array_loader
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sorted_nums [0:N-1],
    output logic [31:0]  out_len
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [W-1:0]   PAD_W    = {W{1'b1}};

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  p_r;
    logic [31:0]    out_len_r;
    logic [W-1:0]   buf_r  [0:N-1];
    logic [W-1:0]   pass_s [0:N-1];
    logic [W-1:0]   lo_s   [0:N-2];
    logic [W-1:0]   hi_s   [0:N-2];
    logic [N-2:0]   pair_en_s;
    logic           accept_s;
    logic           frame_end_s;
    logic           last_pass_s;

    assign accept_s    = in_valid & (state_r == LOAD);
    assign frame_end_s = accept_s & (in_last | (cnt_r == CNT_LAST));
    assign last_pass_s = (p_r == CNT_LAST);

    // Pair i is active on passes whose parity matches the parity of i.
    for (genvar i = 0; i < N - 1; i++) begin : g_pair
        assign pair_en_s[i] = (p_r[0] == 1'((i % 2)));
        cmp_swap #(.W(W)) u_cmp (
            .a  (buf_r[i]),
            .b  (buf_r[i+1]),
            .lo (lo_s[i]),
            .hi (hi_s[i])
        );
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign pass_s[k] = pair_en_s[k] ? lo_s[k] : buf_r[k];
        end else if (k == N - 1) begin : g_tail
            assign pass_s[k] = pair_en_s[k-1] ? hi_s[k-1] : buf_r[k];
        end else begin : g_mid
            assign pass_s[k] = pair_en_s[k]   ? lo_s[k]   :
                               pair_en_s[k-1] ? hi_s[k-1] : buf_r[k];
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (frame_end_s) state_nxt_s = SORT;
                else             state_nxt_s = LOAD;
            end
            SORT: begin
                if (last_pass_s) state_nxt_s = DONE;
                else             state_nxt_s = SORT;
            end
            DONE: begin
                if (out_ready) state_nxt_s = LOAD;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is held low during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            LOAD:    in_ready  = ~rst;
            SORT:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: out_valid = 1'b0;
        endcase
    end

    // State, counters, array storage and frame length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= LOAD;
            cnt_r     <= {CW{1'b0}};
            p_r       <= {CW{1'b0}};
            out_len_r <= 32'd0;
            for (int k = 0; k < N; k++) buf_r[k] <= PAD_W;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        buf_r[cnt_r] <= in_data;
                        cnt_r        <= cnt_r + CW'(1);
                        if (frame_end_s) out_len_r <= 32'(cnt_r) + 32'd1;
                    end
                end
                SORT: begin
                    for (int k = 0; k < N; k++) buf_r[k] <= pass_s[k];
                    p_r <= last_pass_s ? {CW{1'b0}} : p_r + CW'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        for (int k = 0; k < N; k++) buf_r[k] <= PAD_W;
                        cnt_r <= {CW{1'b0}};
                    end
                end
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

    assign sorted_nums = buf_r;
    assign out_len     = out_len_r;

endmodule

// File: tb/tb_sorted_array_loader.sv
// Scoreboard bench: accepted words feed a queue-sort reference model, a monitor checks each frame.
module tb_sorted_array_loader;
    import sort_pkg::*;

    localparam int N = SORT_N;
    localparam int W = SORT_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sorted_nums [0:N-1];
    logic [31:0]  out_len;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int or_mode    = 0;   // 0 random, 1 held low, 2 held high

    logic [W-1:0]   cur_q[$];
    logic [N*W-1:0] exp_flat_q[$];
    int             exp_len_q[$];
    int             exp_acc_q[$];

    sorted_array_loader #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sorted_nums(sorted_nums),
        .out_len    (out_len)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk); #1;
        out_ready = (or_mode == 0) ? 1'($urandom_range(0, 1)) : (or_mode == 2);
    end

    function automatic logic [N*W-1:0] dut_flat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = sorted_nums[i];
        return f;
    endfunction

    // Reference: a frame closes on in_last or on the N-th word; its image is the sorted words then PAD.
    function automatic bit model_accept(logic [W-1:0] d, logic l, int at);
        logic [W-1:0]   s[$];
        logic [N*W-1:0] f;
        cur_q.push_back(d);
        if (l || cur_q.size() == N) begin
            s = cur_q;
            s.sort();
            f = {N{PAD}};
            for (int i = 0; i < s.size(); i++) f[i*W +: W] = s[i];
            exp_flat_q.push_back(f);
            exp_len_q.push_back(s.size());
            exp_acc_q.push_back(at);
            cur_q.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 400) begin @(negedge clk); n++; end
        if (!in_ready) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (model_accept(d, l, cyc)) begin
            compared++;
            if (in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL ready_drop: in_ready=%b after final word, required 0", in_ready);
            end
        end
        if ($urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return W'($urandom_range(0, 7));
            default: return {W{1'b1}};
        endcase
    endfunction

    task automatic wait_drain();
        int n = 0;
        while (exp_len_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (exp_len_q.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: %0d frames pending, required 0", exp_len_q.size());
            exp_flat_q.delete(); exp_len_q.delete(); exp_acc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: latency on frame entry, stability while held, contents on handshake.
    initial begin
        bit             was_v = 1'b0;
        bit             chk_rdy = 1'b0;
        bit             stable = 1'b1;
        logic [N*W-1:0] snap, cur, ef;
        logic [31:0]    snap_len;
        int             el;
        forever begin
            @(negedge clk);
            if (rst) begin
                was_v = 1'b0; chk_rdy = 1'b0;
            end else begin
                if (chk_rdy) begin
                    compared++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                        mismatched++;
                        $display("FAIL reopen: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
                    end
                    chk_rdy = 1'b0;
                end
                if (out_valid === 1'b1) begin
                    cur = dut_flat();
                    if (!was_v) begin
                        snap = cur; snap_len = out_len; stable = 1'b1;
                        compared++;
                        if (exp_acc_q.size() == 0) begin
                            mismatched++;
                            $display("FAIL latency: frame with no expected entry");
                        end else if (cyc - exp_acc_q[0] != N) begin
                            mismatched++;
                            $display("FAIL latency: got %0d edges, required %0d", cyc - exp_acc_q[0], N);
                        end
                    end else if (cur !== snap || out_len !== snap_len) begin
                        stable = 1'b0;
                    end
                    if (out_ready === 1'b1) begin
                        compared++;
                        if (exp_len_q.size() == 0) begin
                            mismatched++;
                            $display("FAIL frame: unexpected frame len=%0d", out_len);
                        end else begin
                            ef = exp_flat_q.pop_front();
                            el = exp_len_q.pop_front();
                            void'(exp_acc_q.pop_front());
                            if (out_len !== 32'(el)) begin
                                mismatched++;
                                $display("FAIL out_len: got %0d, required %0d", out_len, el);
                            end
                            compared++;
                            if (cur !== ef) begin
                                mismatched++;
                                for (int i = 0; i < N; i++)
                                    if (cur[i*W +: W] !== ef[i*W +: W]) begin
                                        $display("FAIL sorted_nums[%0d]: got %h, required %h", i, cur[i*W +: W], ef[i*W +: W]);
                                        break;
                                    end
                            end
                            compared++;
                            if (!stable) begin
                                mismatched++;
                                $display("FAIL hold: frame changed while out_valid=1, required stable");
                            end
                            chk_rdy = 1'b1;
                        end
                    end
                end
                was_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        compared += 4;
        if (in_ready !== 1'b0)  begin mismatched++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_len !== 32'd0)  begin mismatched++; $display("FAIL rst_out_len: got %0d, required 0", out_len); end
        if (dut_flat() !== {N{PAD}}) begin mismatched++; $display("FAIL rst_pad: array not all PAD"); end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %b, required 1", in_ready); end

        // Reversed full frame, short frame with duplicates, single word.
        for (int i = 0; i < N; i++) send_word(W'(N - 1 - i), i == N - 1);
        wait_drain();
        send_word(32'd5, 1'b0); send_word(32'd1, 1'b0); send_word(32'd5, 1'b0); send_word(32'd3, 1'b1);
        wait_drain();
        send_word(32'd7, 1'b1);
        wait_drain();

        // N words without in_last, then one more that must open the next frame.
        for (int i = 0; i < N; i++) send_word(rand_word(), 1'b0);
        send_word(32'd9, 1'b1);
        wait_drain();

        // Backpressure: hold the frame for 10 cycles, then release.
        or_mode = 1;
        send_word(32'd40, 1'b0); send_word(32'd20, 1'b0); send_word(32'hFFFF_FFFF, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL backpressure_valid: got %b, required 1", out_valid); end
            @(negedge clk);
        end
        or_mode = 2;
        wait_drain();
        or_mode = 0;

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(1, N);
            for (int i = 0; i < len; i++) send_word(rand_word(), i == len - 1);
        end
        wait_drain();

        // Reset during SORT: no frame may appear, next frame starts clean.
        for (int i = 0; i < N; i++) send_word(rand_word(), i == N - 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared += 3;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b0)  begin mismatched++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
        if (out_len !== 32'd0)  begin mismatched++; $display("FAIL midrst_out_len: got %0d, required 0", out_len); end
        exp_flat_q.delete(); exp_len_q.delete(); exp_acc_q.delete(); cur_q.delete();
        rst = 1'b0;
        @(negedge clk);
        send_word(32'd2, 1'b0); send_word(32'd2, 1'b0); send_word(32'd1, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
